// File: rtl/music_box_pkg.sv
// Shared definitions for the music-key input path.
//   NUM_MUSIC_KEYS       number of music pushbuttons
//   DEBOUNCE_MS_DEFAULT  1 kHz samples a new key level must hold before acceptance
//   FIFO_DEPTH_DEFAULT   depth of the key-event queue
//   key_event_t          one queued event: key index plus press/release flag
package music_box_pkg;

    localparam int NUM_MUSIC_KEYS      = 6;
    localparam int DEBOUNCE_MS_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT  = 4;

    typedef struct packed {
        logic [2:0] key;
        logic       is_press;
    } key_event_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One key's conditioning: 2-flop synchronizer, stability counter, debounced
// level and one-cycle press/release pulses.
//   clk             1 kHz tick clock
//   reset           synchronous, active-high
//   raw             raw button, active-low, asynchronous
//   level           debounced level, active-low (1 = released)
//   pressed_pulse   registered 1-cycle pulse on an accepted 1->0 change
//   released_pulse  registered 1-cycle pulse on an accepted 0->1 change
//   press_edge      combinational: a 1->0 change is accepted at the coming edge
//   release_edge    combinational: a 0->1 change is accepted at the coming edge
module key_debounce_channel #(
    parameter int DEBOUNCE_MS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed_pulse,
    output logic released_pulse,
    output logic press_edge,
    output logic release_edge
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The change is accepted on the edge where the counter has already seen
    // DEBOUNCE_MS-1 disagreeing samples; the edge strobes let the event logic
    // register the edge in the same cycle as the level change.
    assign accept       = (sync_q[1] != level) && (cnt == CNT_W'(DEBOUNCE_MS - 1));
    assign press_edge   = accept && !sync_q[1];
    assign release_edge = accept &&  sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes the 2-flop chain a chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q         <= 2'b11;
            level          <= 1'b1;
            cnt            <= '0;
            pressed_pulse  <= 1'b0;
            released_pulse <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], raw};
            pressed_pulse  <= press_edge;
            released_pulse <= release_edge;
            if (sync_q[1] == level) begin
                cnt <= '0;            // agreement or bounce-back restarts the count
            end else if (accept) begin
                level <= sync_q[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/music_key_debouncer.sv
// Conditioning stage for the music-key pushbuttons on the 1 kHz clock:
// per-key debounce channels, a pending-edge set, a fixed-priority arbiter and
// a small valid/ready event queue for the recording path.
//   CLK_1Khz            1 kHz system tick clock
//   reset               synchronous, active-high
//   raw_MusicKey        raw buttons, active-low, bouncy
//   events_enable       1 = accepted edges are queued as events
//   debounced_MusicKey  debounced levels, active-low (1 = released)
//   key_pressed_pulse   1-cycle pulse per accepted press
//   key_released_pulse  1-cycle pulse per accepted release
//   event_valid         queue head valid
//   event_ready         consumer takes the head this cycle
//   event_key           key index of the head event
//   event_is_press      1 = press, 0 = release
//   event_overflow      sticky: an edge was lost (cleared only by reset)
module music_key_debouncer
    import music_box_pkg::*;
#(
    parameter int NUM_KEYS    = NUM_MUSIC_KEYS,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
    input  logic                CLK_1Khz,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] raw_MusicKey,
    input  logic                events_enable,
    output logic [NUM_KEYS-1:0] debounced_MusicKey,
    output logic [NUM_KEYS-1:0] key_pressed_pulse,
    output logic [NUM_KEYS-1:0] key_released_pulse,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [2:0]          event_key,
    output logic                event_is_press,
    output logic                event_overflow
);

    localparam int PEND_W = 2 * NUM_KEYS;
    localparam int IDX_W  = $clog2(PEND_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [NUM_KEYS-1:0] press_edge;
    logic [NUM_KEYS-1:0] release_edge;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_channel (
            .clk            (CLK_1Khz),
            .reset          (reset),
            .raw            (raw_MusicKey[i]),
            .level          (debounced_MusicKey[i]),
            .pressed_pulse  (key_pressed_pulse[i]),
            .released_pulse (key_released_pulse[i]),
            .press_edge     (press_edge[i]),
            .release_edge   (release_edge[i])
        );
    end

    // Pending vector: presses in the low half, releases in the high half, so
    // the lowest set index gives all presses before releases, lower key first.
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_next;
    logic [PEND_W-1:0] edge_vec;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  key_idx;
    logic              overflow_hit;

    key_event_t        mem [FIFO_DEPTH];
    key_event_t        push_event;
    key_event_t        head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    assign edge_vec = {release_edge, press_edge};

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = PEND_W - 1; j >= 0; j--) begin
            if (pend[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Fullness is judged on the registered count: a pop in the same cycle
    // does not make room, the arbiter simply retries next cycle.
    assign push = win_found && (count != CNT_W'(FIFO_DEPTH));
    assign pop  = event_valid && event_ready;

    always_comb begin
        key_idx             = win_idx[IDX_W-1:0] - IDX_W'(NUM_KEYS);
        push_event.is_press = (win_idx < IDX_W'(NUM_KEYS));
        if (push_event.is_press) begin
            key_idx = win_idx;
        end
        push_event.key = 3'(key_idx);
    end

    always_comb begin
        pend_next    = pend;
        overflow_hit = 1'b0;
        if (push) begin
            pend_next[win_idx] = 1'b0;
        end
        if (events_enable) begin
            for (int j = 0; j < PEND_W; j++) begin
                if (edge_vec[j]) begin
                    // A bit leaving for the queue this cycle frees its slot,
                    // so the new edge is kept rather than counted as lost.
                    if (pend[j] && !(push && win_idx == IDX_W'(j))) begin
                        overflow_hit = 1'b1;
                    end
                    pend_next[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_1Khz) begin
        if (reset) begin
            pend           <= '0;
            event_overflow <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            pend <= pend_next;
            if (overflow_hit) begin
                event_overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the queue storage has no reset; an entry is only visible after it
    // has been written, and the head outputs are forced to zero while empty.
    always_ff @(posedge CLK_1Khz) begin
        if (push) begin
            mem[wr_ptr] <= push_event;
        end
    end

    assign head           = mem[rd_ptr];
    assign event_valid    = (count != '0);
    assign event_key      = event_valid ? head.key      : 3'd0;
    assign event_is_press = event_valid ? head.is_press : 1'b0;

endmodule

// File: tb/tb_music_key_debouncer.sv
module tb_music_key_debouncer;
    import music_box_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] raw;
    logic       events_enable;
    logic [5:0] debounced;
    logic [5:0] pressed_pulse;
    logic [5:0] released_pulse;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_key;
    logic       event_is_press;
    logic       event_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    music_key_debouncer dut (
        .CLK_1Khz           (clk),
        .reset              (reset),
        .raw_MusicKey       (raw),
        .events_enable      (events_enable),
        .debounced_MusicKey (debounced),
        .key_pressed_pulse  (pressed_pulse),
        .key_released_pulse (released_pulse),
        .event_valid        (event_valid),
        .event_ready        (event_ready),
        .event_key          (event_key),
        .event_is_press     (event_is_press),
        .event_overflow     (event_overflow)
    );

    typedef struct {
        logic [5:0] raw;
        logic       en;
        logic [5:0] exp_deb;
        logic       exp_valid;
        logic [2:0] exp_key;
        logic       exp_press;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs
    // driven 1 time unit after it.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Requires event_ready=1: waits up to budget cycles for a head, checks
    // it, then steps once so the head is consumed.
    task automatic wait_event(input string name, input logic [2:0] k, input logic p,
                              input int budget);
        int waited = 0;
        while (!event_valid && waited < budget) begin
            step();
            waited++;
        end
        check({name, "_valid"}, event_valid, 1);
        if (event_valid) begin
            check({name, "_key"}, event_key, k);
            check({name, "_press"}, event_is_press, p);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_pulse;
        int npulse;
        int nevt;
        logic [2:0] evt_key;
        logic [2:0] exp3 [3];

        vecs[0] = '{6'b111110, 1'b1, 6'b111110, 1'b1, 3'd0, 1'b1};
        vecs[1] = '{6'b111111, 1'b1, 6'b111111, 1'b1, 3'd0, 1'b0};
        vecs[2] = '{6'b011111, 1'b0, 6'b011111, 1'b0, 3'd0, 1'b0};
        vecs[3] = '{6'b111111, 1'b1, 6'b111111, 1'b1, 3'd5, 1'b0};
        vecs[4] = '{6'b111011, 1'b1, 6'b111011, 1'b1, 3'd2, 1'b1};
        vecs[5] = '{6'b111111, 1'b0, 6'b111111, 1'b0, 3'd0, 1'b0};
        exp3 = '{3'd1, 3'd3, 3'd5};

        reset         = 1'b1;
        raw           = 6'h3f;
        events_enable = 1'b1;
        event_ready   = 1'b0;
        step(3);
        check("rst_deb", debounced, 6'h3f);
        check("rst_ppulse", pressed_pulse, 0);
        check("rst_rpulse", released_pulse, 0);
        check("rst_valid", event_valid, 0);
        check("rst_key", event_key, 0);
        check("rst_press", event_is_press, 0);
        check("rst_ovf", event_overflow, 0);
        reset = 1'b0;
        step(2);

        // Clean press of key 2: level and pulse at E+9, event at E+10.
        raw[2] = 1'b0;
        step(9);
        check("t1_deb_e8", debounced[2], 1);
        check("t1_pulse_e8", pressed_pulse[2], 0);
        step();
        check("t1_deb_e9", debounced[2], 0);
        check("t1_pulse_e9", pressed_pulse, 6'b000100);
        check("t1_valid_e9", event_valid, 0);
        step();
        check("t1_pulse_e10", pressed_pulse[2], 0);
        check("t1_valid_e10", event_valid, 1);
        check("t1_key_e10", event_key, 2);
        check("t1_press_e10", event_is_press, 1);
        event_ready = 1'b1;
        step();
        check("t1_pop", event_valid, 0);
        raw[2] = 1'b1;
        wait_event("t1_rel", 3'd2, 1'b0, 15);

        // Key 0 bounces every 3 cycles, final 0 from step 12: pulse at step 21.
        first_pulse = -1;
        npulse      = 0;
        nevt        = 0;
        evt_key     = 3'd7;
        for (int i = 0; i < 28; i++) begin
            raw[0] = (i < 12) ? 1'((i / 3) % 2) : 1'b0;
            step();
            if (pressed_pulse[0]) begin
                npulse++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (event_valid) begin
                nevt++;
                evt_key = event_key;
            end
        end
        check("t2_first_pulse", first_pulse, 21);
        check("t2_npulse", npulse, 1);
        check("t2_nevt", nevt, 1);
        check("t2_evt_key", evt_key, 0);
        raw[0] = 1'b1;
        wait_event("t2_rel", 3'd0, 1'b0, 15);

        // Keys 1, 3, 5 together: events in consecutive cycles, lower key first.
        raw = 6'b010101;
        for (int j = 0; j < 3; j++)
            wait_event($sformatf("t3_p%0d", j), exp3[j], 1'b1, (j == 0) ? 15 : 0);
        check("t3_ovf", event_overflow, 0);
        raw = 6'h3f;
        for (int j = 0; j < 3; j++)
            wait_event($sformatf("t3_r%0d", j), exp3[j], 1'b0, (j == 0) ? 15 : 0);

        // Stalled consumer, keys 0..5 pressed one cycle apart.
        event_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            raw[k] = 1'b0;
            step();
        end
        step(15);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t4_stall_valid%0d", c), event_valid, 1);
            check($sformatf("t4_stall_key%0d", c), event_key, 0);
            check($sformatf("t4_stall_press%0d", c), event_is_press, 1);
            step();
        end
        check("t4_ovf", event_overflow, 0);
        event_ready = 1'b1;
        for (int k = 0; k < 6; k++)
            wait_event($sformatf("t4_p%0d", k), 3'(k), 1'b1, 2);
        raw = 6'h3f;
        for (int k = 0; k < 6; k++)
            wait_event($sformatf("t4_r%0d", k), 3'(k), 1'b0, (k == 0) ? 15 : 2);
        step(3);
        check("t4_empty", event_valid, 0);

        // Fill the queue, then press/release/press key 4: the second press
        // finds press_pend[4] still set.
        event_ready = 1'b0;
        raw = 6'b110000;
        step(15);
        raw[4] = 1'b0;
        step(12);
        raw[4] = 1'b1;
        step(12);
        check("t5_ovf_before", event_overflow, 0);
        raw[4] = 1'b0;
        step(12);
        check("t5_ovf_set", event_overflow, 1);
        event_ready = 1'b1;
        for (int k = 0; k < 5; k++)
            wait_event($sformatf("t5_p%0d", k), 3'(k), 1'b1, 2);
        wait_event("t5_r4", 3'd4, 1'b0, 2);
        raw = 6'h3f;
        for (int k = 0; k < 5; k++)
            wait_event($sformatf("t5_rr%0d", k), 3'(k), 1'b0, (k == 0) ? 15 : 2);
        check("t5_ovf_sticky", event_overflow, 1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("t5_ovf_cleared", event_overflow, 0);
        step(2);

        // Table of single-key changes with the consumer stalled.
        event_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            raw           = vecs[r].raw;
            events_enable = vecs[r].en;
            step(12);
            check($sformatf("tbl%0d_deb", r), debounced, vecs[r].exp_deb);
            check($sformatf("tbl%0d_valid", r), event_valid, vecs[r].exp_valid);
            check($sformatf("tbl%0d_ovf", r), event_overflow, 0);
            if (vecs[r].exp_valid) begin
                check($sformatf("tbl%0d_key", r), event_key, vecs[r].exp_key);
                check($sformatf("tbl%0d_press", r), event_is_press, vecs[r].exp_press);
                event_ready = 1'b1;
                step();
                event_ready = 1'b0;
                check($sformatf("tbl%0d_popped", r), event_valid, 0);
            end
        end
        events_enable = 1'b1;

        // Reset with events queued and key 3 held through it.
        raw = 6'b110101;
        step(14);
        check("t6_queued", event_valid, 1);
        reset  = 1'b1;
        raw[1] = 1'b1;
        step();
        check("t6_rst_valid", event_valid, 0);
        check("t6_rst_deb", debounced, 6'h3f);
        check("t6_rst_ovf", event_overflow, 0);
        step();
        reset = 1'b0;
        step(9);
        check("t6_deb_e8", debounced[3], 1);
        step();
        check("t6_deb_e9", debounced[3], 0);
        check("t6_valid_e9", event_valid, 0);
        step();
        check("t6_valid_e10", event_valid, 1);
        check("t6_key_e10", event_key, 3);
        check("t6_press_e10", event_is_press, 1);
        event_ready = 1'b1;
        step(5);
        check("t6_only_one", event_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
